// File: rtl/ip_demux_ctrl.sv
// Per-frame classifier/sequencer for ip_demux: matches header fields against M_COUNT rules
// and holds enable/drop/select until the frame's tlast beat. Optional counters: IP_DEMUX_CTRL_STATS_EN.
module ip_demux_ctrl #(
   parameter int unsigned M_COUNT      = 4,
   parameter int unsigned SELECT_WIDTH = $clog2(M_COUNT)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_ip_hdr_valid,
   input  logic                      s_ip_hdr_ready,
   input  logic [7:0]                s_ip_protocol,
   input  logic [31:0]               s_ip_dest_ip,
   input  logic                      s_ip_payload_axis_tvalid,
   input  logic                      s_ip_payload_axis_tready,
   input  logic                      s_ip_payload_axis_tlast,
   input  logic [M_COUNT-1:0]        cfg_rule_valid,
   input  logic [M_COUNT*8-1:0]      cfg_rule_protocol,
   input  logic [M_COUNT-1:0]        cfg_rule_proto_any,
   input  logic [M_COUNT*32-1:0]     cfg_rule_ip,
   input  logic [M_COUNT*32-1:0]     cfg_rule_ip_mask,
   output logic                      enable,
   output logic                      drop,
   output logic [SELECT_WIDTH-1:0]   select,
   output logic                      busy
`ifdef IP_DEMUX_CTRL_STATS_EN
   ,
   input  logic                      stat_clear,
   output logic [M_COUNT*16-1:0]     stat_frames,
   output logic [15:0]               stat_drops
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ROUTE,
      ST_PAYLOAD
   } state_t;

   state_t                  state_q, state_d;
   logic                    enable_q, enable_d;
   logic                    busy_q, busy_d;
   logic                    drop_q, drop_d;
   logic [SELECT_WIDTH-1:0] select_q, select_d;

   logic [M_COUNT-1:0]      rule_hit;
   logic                    match_any;
   logic [SELECT_WIDTH-1:0] match_idx;
   logic                    hdr_acc;
   logic                    last_acc;

   // Per-rule compare; purely combinational in front of the decision register
   always_comb begin
      for (int i = 0; i < M_COUNT; i++) begin
         rule_hit[i] = cfg_rule_valid[i]
                    && (cfg_rule_proto_any[i] || (s_ip_protocol == cfg_rule_protocol[8*i +: 8]))
                    && (((s_ip_dest_ip ^ cfg_rule_ip[32*i +: 32]) & cfg_rule_ip_mask[32*i +: 32]) == 32'd0);
      end
   end

   // Lowest matching index wins: scan downward so the last hit written is the lowest
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = M_COUNT - 1; i >= 0; i--) begin
         if (rule_hit[i]) begin
            match_any = 1'b1;
            match_idx = SELECT_WIDTH'(i);
         end
      end
   end

   assign hdr_acc  = (state_q == ST_ROUTE) && s_ip_hdr_valid && s_ip_hdr_ready;
   assign last_acc = (state_q == ST_PAYLOAD) && s_ip_payload_axis_tvalid
                  && s_ip_payload_axis_tready && s_ip_payload_axis_tlast;

   // Next-state and registered-output logic
   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      drop_d   = drop_q;
      case (state_q)
         ST_IDLE: begin
            if (s_ip_hdr_valid) begin
               select_d = match_any ? match_idx : '0;
               drop_d   = ~match_any;
               state_d  = ST_ROUTE;
            end
         end
         ST_ROUTE: begin
            if (hdr_acc) state_d = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (last_acc) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      enable_d = (state_d != ST_IDLE);
      busy_d   = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         enable_q <= 1'b0;
         busy_q   <= 1'b0;
         drop_q   <= 1'b0;
         select_q <= '0;
      end else begin
         state_q  <= state_d;
         enable_q <= enable_d;
         busy_q   <= busy_d;
         drop_q   <= drop_d;
         select_q <= select_d;
      end
   end

   assign enable = enable_q;
   assign busy   = busy_q;
   assign drop   = drop_q;
   assign select = select_q;

`ifdef IP_DEMUX_CTRL_STATS_EN
   localparam int unsigned     STAT_W   = 16;
   localparam logic [STAT_W-1:0] STAT_MAX = '1;

   logic [STAT_W-1:0] frames_q [M_COUNT];
   logic [STAT_W-1:0] frames_d [M_COUNT];
   logic [STAT_W-1:0] drops_q, drops_d;

   // Saturating counters bumped on header acceptance; clear has priority
   always_comb begin
      frames_d = frames_q;
      drops_d  = drops_q;
      if (stat_clear) begin
         for (int i = 0; i < M_COUNT; i++) frames_d[i] = '0;
         drops_d = '0;
      end else if (hdr_acc) begin
         if (drop_q) begin
            if (drops_q != STAT_MAX) drops_d = drops_q + STAT_W'(1);
         end else begin
            for (int i = 0; i < M_COUNT; i++) begin
               if ((select_q == SELECT_WIDTH'(i)) && (frames_q[i] != STAT_MAX))
                  frames_d[i] = frames_q[i] + STAT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < M_COUNT; i++) frames_q[i] <= '0;
         drops_q <= '0;
      end else begin
         frames_q <= frames_d;
         drops_q  <= drops_d;
      end
   end

   always_comb begin
      for (int i = 0; i < M_COUNT; i++) stat_frames[16*i +: 16] = frames_q[i];
   end
   assign stat_drops = drops_q;
`endif

endmodule

// File: tb/tb_ip_demux_ctrl.sv
// Randomized bench for ip_demux_ctrl: the bench plays source and ip_demux handshakes and
// checks every cycle against a frame-level reference built from the rule-matching rules.
module tb_ip_demux_ctrl;

   localparam int unsigned M  = 4;
   localparam int unsigned SW = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            s_ip_hdr_valid, s_ip_hdr_ready;
   logic [7:0]      s_ip_protocol;
   logic [31:0]     s_ip_dest_ip;
   logic            tvalid, tready, tlast;
   logic [M-1:0]    cfg_rule_valid, cfg_rule_proto_any;
   logic [M*8-1:0]  cfg_rule_protocol;
   logic [M*32-1:0] cfg_rule_ip, cfg_rule_ip_mask;
   logic            enable, drop, busy;
   logic [SW-1:0]   select;
`ifdef IP_DEMUX_CTRL_STATS_EN
   logic            stat_clear;
   logic [M*16-1:0] stat_frames;
   logic [15:0]     stat_drops;
`endif

   ip_demux_ctrl #(.M_COUNT(M), .SELECT_WIDTH(SW)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .s_ip_hdr_valid           (s_ip_hdr_valid),
      .s_ip_hdr_ready           (s_ip_hdr_ready),
      .s_ip_protocol            (s_ip_protocol),
      .s_ip_dest_ip             (s_ip_dest_ip),
      .s_ip_payload_axis_tvalid (tvalid),
      .s_ip_payload_axis_tready (tready),
      .s_ip_payload_axis_tlast  (tlast),
      .cfg_rule_valid           (cfg_rule_valid),
      .cfg_rule_protocol        (cfg_rule_protocol),
      .cfg_rule_proto_any       (cfg_rule_proto_any),
      .cfg_rule_ip              (cfg_rule_ip),
      .cfg_rule_ip_mask         (cfg_rule_ip_mask),
      .enable                   (enable),
      .drop                     (drop),
      .select                   (select),
      .busy                     (busy)
`ifdef IP_DEMUX_CTRL_STATS_EN
      ,
      .stat_clear               (stat_clear),
      .stat_frames              (stat_frames),
      .stat_drops               (stat_drops)
`endif
   );

   // Rule table as the bench sees it
   bit        rval [M];
   bit        rany [M];
   bit [7:0]  rp   [M];
   bit [31:0] rip  [M];
   bit [31:0] rmask[M];
   int        exp_frames[M];
   int        exp_drops;

   always_comb begin
      for (int i = 0; i < M; i++) begin
         cfg_rule_valid[i]           = rval[i];
         cfg_rule_proto_any[i]       = rany[i];
         cfg_rule_protocol[8*i +: 8] = rp[i];
         cfg_rule_ip[32*i +: 32]     = rip[i];
         cfg_rule_ip_mask[32*i +: 32] = rmask[i];
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decision: {drop, select}
   function automatic logic [SW:0] classify(input bit [7:0] p, input bit [31:0] ip);
      for (int i = 0; i < M; i++) begin
         if (rval[i] && (rany[i] || p == rp[i]) && (((ip ^ rip[i]) & rmask[i]) == 32'd0))
            return {1'b0, SW'(i)};
      end
      return {1'b1, SW'(0)};
   endfunction

   task automatic chk_state(input string tag, input bit en, input logic [SW:0] d);
      check_eq({tag, "_en"}, 32'(enable), 32'(en));
      check_eq({tag, "_busy"}, 32'(busy), 32'(en));
      if (en) begin
         check_eq({tag, "_sel"}, 32'(select), 32'(d[SW-1:0]));
         check_eq({tag, "_drop"}, 32'(drop), 32'(d[SW]));
      end
   endtask

   task automatic chk_stats(input string tag);
`ifdef IP_DEMUX_CTRL_STATS_EN
      for (int i = 0; i < M; i++) check_eq({tag, "_frames"}, 32'(stat_frames[16*i +: 16]), 32'(exp_frames[i]));
      check_eq({tag, "_drops"}, 32'(stat_drops), 32'(exp_drops));
`else
      check_eq({tag, "_busy_idle"}, 32'(busy), 32'd0);
`endif
   endtask

   task automatic idle_inputs();
      s_ip_hdr_valid = 1'b0;
      s_ip_hdr_ready = 1'b0;
      tvalid = 1'b0;
      tready = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic clear_model();
      for (int i = 0; i < M; i++) exp_frames[i] = 0;
      exp_drops = 0;
   endtask

   task automatic clear_cfg();
      for (int i = 0; i < M; i++) begin
         rval[i] = 0; rany[i] = 0; rp[i] = 8'h00; rip[i] = 32'h0; rmask[i] = 32'h0;
      end
   endtask

   // One frame; entered and left at a negedge with the DUT idle (or about to classify if b2b_in)
   task automatic run_frame(input bit [7:0] p, input bit [31:0] ip, input int nbeats,
                            input bit b2b_in, input bit b2b_out, input bit [7:0] np,
                            input bit [31:0] nip, input bit mutate, input int rst_beat);
      logic [SW:0] d;
      int beat, cyc, nwait;
      bit hs;
      if (!b2b_in) begin
         int gap = $urandom_range(0, 2);
         repeat (gap) begin
            tvalid = 1'($urandom_range(0, 1));
            tready = 1'($urandom_range(0, 1));
            tlast  = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_state("gap", 1'b0, '0);
         end
         s_ip_protocol  = p;
         s_ip_dest_ip   = ip;
         s_ip_hdr_valid = 1'b1;
         s_ip_hdr_ready = 1'b0;
      end
      d = classify(p, ip);
      @(negedge clk);
      chk_state("cls", 1'b1, d);
      nwait = $urandom_range(0, 2);
      for (int w = 0; w <= nwait; w++) begin
         s_ip_hdr_ready = (w == nwait);
         tvalid = 1'($urandom_range(0, 1));
         tready = 1'($urandom_range(0, 1));
         tlast  = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk_state("route", 1'b1, d);
      end
      idle_inputs();
      if (d[SW]) begin
         if (exp_drops < 65535) exp_drops++;
      end else if (exp_frames[d[SW-1:0]] < 65535) begin
         exp_frames[d[SW-1:0]]++;
      end
      beat = 0;
      cyc  = 0;
      while (beat < nbeats) begin
         if (beat == rst_beat) begin
            rst = 1'b1;
            #1;
            check_eq("rst_en", 32'(enable), 32'd0);
            check_eq("rst_drop", 32'(drop), 32'd0);
            check_eq("rst_sel", 32'(select), 32'd0);
            check_eq("rst_busy", 32'(busy), 32'd0);
            clear_model();
            chk_stats("rst");
            idle_inputs();
            @(negedge clk);
            rst = 1'b0;
            chk_state("post_rst", 1'b0, '0);
            return;
         end
         if (mutate && cyc == 0) rip[2] = rip[2] ^ 32'h0000_0300;
         tvalid = (cyc > 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
         tready = (cyc > 50) ? 1'b1 : ($urandom_range(0, 3) != 0);
         tlast  = (beat == nbeats - 1);
         hs = tvalid && tready;
         if (hs && tlast) begin
            s_ip_hdr_valid = b2b_out;
            s_ip_hdr_ready = 1'b0;
            if (b2b_out) begin
               s_ip_protocol = np;
               s_ip_dest_ip  = nip;
            end
         end else begin
            s_ip_hdr_valid = ($urandom_range(0, 3) == 0);
            s_ip_hdr_ready = 1'($urandom_range(0, 1));
            s_ip_protocol  = 8'($urandom);
         end
         @(negedge clk);
         cyc++;
         if (hs) beat++;
         if (beat == nbeats) chk_state("end", 1'b0, d);
         else                chk_state("pay", 1'b1, d);
      end
      tvalid = 1'b0;
      tready = 1'b0;
      tlast  = 1'b0;
      if (!b2b_out) begin
         s_ip_hdr_valid = 1'b0;
         s_ip_hdr_ready = 1'b0;
      end
   endtask

   function automatic bit [7:0] rnd_proto();
      case ($urandom_range(0, 3))
         0: return 8'h06;
         1: return 8'h11;
         2: return 8'h01;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic bit [31:0] rnd_ip();
      return 32'h0A00_0000 | 32'($urandom_range(0, 3) << 8) | 32'($urandom_range(0, 3));
   endfunction

   task automatic rnd_cfg();
      for (int i = 0; i < M; i++) begin
         rval[i] = ($urandom_range(0, 1) == 1);
         rany[i] = ($urandom_range(0, 9) < 3);
         rp[i]   = rnd_proto();
         rip[i]  = rnd_ip();
         case ($urandom_range(0, 3))
            0: rmask[i] = 32'h0000_0000;
            1: rmask[i] = 32'hFFFF_FF00;
            2: rmask[i] = 32'hFFFF_FFFF;
            default: rmask[i] = 32'hFFFF_FCFF;
         endcase
      end
   endtask

   task automatic rule2_udp();
      clear_cfg();
      rval[2] = 1; rp[2] = 8'h11; rip[2] = 32'hC0A8_0100; rmask[2] = 32'hFFFF_FF00;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bit [7:0]  cp, np;
      bit [31:0] cip, nip;
      bit        bin, bout;
      int        nb, rb;
      rst = 1'b1;
      idle_inputs();
      s_ip_protocol = 8'h00;
      s_ip_dest_ip  = 32'h0;
`ifdef IP_DEMUX_CTRL_STATS_EN
      stat_clear = 1'b0;
`endif
      clear_cfg();
      clear_model();
      repeat (2) @(negedge clk);
      check_eq("reset_en", 32'(enable), 32'd0);
      check_eq("reset_drop", 32'(drop), 32'd0);
      check_eq("reset_sel", 32'(select), 32'd0);
      check_eq("reset_busy", 32'(busy), 32'd0);
      chk_stats("reset");
      rst = 1'b0;
      @(negedge clk);
      chk_state("idle", 1'b0, '0);

      // UDP to 192.168.1.77 routed by rule 2
      rule2_udp();
      run_frame(8'h11, 32'hC0A8_014D, 3, 0, 0, 8'h0, 32'h0, 0, -1);

      // Overlapping rules 1 and 3, then rule 1 disabled
      clear_cfg();
      rval[1] = 1; rany[1] = 1; rval[3] = 1; rany[3] = 1;
      run_frame(8'h06, 32'h0102_0304, 2, 0, 0, 8'h0, 32'h0, 0, -1);
      rval[1] = 0;
      run_frame(8'h06, 32'h0102_0304, 2, 0, 0, 8'h0, 32'h0, 0, -1);

      // TCP with only a UDP rule: dropped
      clear_cfg();
      rval[0] = 1; rp[0] = 8'h11;
      run_frame(8'h06, 32'h0A00_0001, 2, 0, 0, 8'h0, 32'h0, 0, -1);
      chk_stats("drop");

      // Back-to-back with header waiting at tlast
      rval[3] = 1; rp[3] = 8'h06;
      run_frame(8'h11, 32'h0A00_0001, 3, 0, 1, 8'h06, 32'h0A00_0002, 0, -1);
      run_frame(8'h06, 32'h0A00_0002, 2, 1, 0, 8'h0, 32'h0, 0, -1);

      // Rule change during payload affects only the next frame
      rule2_udp();
      run_frame(8'h11, 32'hC0A8_014D, 4, 0, 0, 8'h0, 32'h0, 1, -1);
      run_frame(8'h11, 32'hC0A8_014D, 2, 0, 0, 8'h0, 32'h0, 0, -1);

      // Reset during payload beat 2 of 4, then a normal frame
      rule2_udp();
      run_frame(8'h11, 32'hC0A8_014D, 4, 0, 0, 8'h0, 32'h0, 0, 1);
      run_frame(8'h11, 32'hC0A8_0105, 3, 0, 0, 8'h0, 32'h0, 0, -1);

      // Randomized frames and configurations
      cp  = rnd_proto();
      cip = rnd_ip();
      bin = 0;
      for (int k = 0; k < 200; k++) begin
         if (k % 10 == 0) rnd_cfg();
         nb   = $urandom_range(1, 5);
         np   = rnd_proto();
         nip  = rnd_ip();
         rb   = ($urandom_range(0, 29) == 0) ? $urandom_range(0, nb - 1) : -1;
         bout = (rb < 0) && ($urandom_range(0, 1) == 1);
         run_frame(cp, cip, nb, bin, bout, np, nip, ($urandom_range(0, 7) == 0), rb);
         cp  = np;
         cip = nip;
         bin = bout;
      end
      if (bin) run_frame(cp, cip, 1, 1, 0, 8'h0, 32'h0, 0, -1);

      @(negedge clk);
      chk_stats("final");
`ifdef IP_DEMUX_CTRL_STATS_EN
      stat_clear = 1'b1;
      @(negedge clk);
      stat_clear = 1'b0;
      clear_model();
      chk_stats("clear");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ip_demux_ctrl.md
# ip_demux_ctrl

Per-frame classifier and sequencer for `ip_demux`. It snoops the IP header and payload handshakes on the demux input and matches `ip_protocol`/`ip_dest_ip` against M_COUNT programmable rules. It drives `enable`, `drop` and `select` so the demux routes each frame to the rule-selected output, or discards it. Decisions are latched per frame and held stable until the frame's final payload beat completes.

## Interface
Parameters:
- M_COUNT, 4, number of demux outputs / rules (2..16)
- SELECT_WIDTH, $clog2(M_COUNT), width of `select`

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- s_ip_hdr_valid  input  1  demux input header valid (snooped)
- s_ip_hdr_ready  input  1  demux input header ready (from ip_demux)
- s_ip_protocol  input  8  header protocol field
- s_ip_dest_ip  input  32  header destination IP
- s_ip_payload_axis_tvalid  input  1  payload valid (snooped)
- s_ip_payload_axis_tready  input  1  payload ready (from ip_demux)
- s_ip_payload_axis_tlast  input  1  payload last
- cfg_rule_valid  input  M_COUNT  per-rule enable
- cfg_rule_protocol  input  M_COUNT*8  rule i protocol, bits [8i+7:8i]
- cfg_rule_proto_any  input  M_COUNT  rule i ignores protocol
- cfg_rule_ip  input  M_COUNT*32  rule i dest IP
- cfg_rule_ip_mask  input  M_COUNT*32  rule i IP mask (1 = compare bit)
- enable  output  1  to ip_demux `enable`
- drop  output  1  to ip_demux `drop`
- select  output  SELECT_WIDTH  to ip_demux `select`
- busy  output  1  frame in progress (state != IDLE)

## Operation
- Rule i matches when all of the following hold:
  - cfg_rule_valid[i] is set.
  - cfg_rule_proto_any[i] is set, or s_ip_protocol == cfg_rule_protocol[i].
  - (s_ip_dest_ip ^ cfg_rule_ip[i]) & cfg_rule_ip_mask[i] == 0.
- The lowest matching index wins. With no match: drop=1, select=0.
- FSM states: IDLE, ROUTE, PAYLOAD.
  - IDLE: enable=0, so the demux cannot accept the header. When s_ip_hdr_valid=1, register the match result into select/drop and go to ROUTE.
  - ROUTE: enable=1 and select/drop are held. On s_ip_hdr_valid && s_ip_hdr_ready, go to PAYLOAD.
  - PAYLOAD: enable=1 and select/drop are held. On s_ip_payload_axis_tvalid && tready && tlast, go to IDLE with enable=0 in the next cycle.
- Config inputs are sampled only in the IDLE→ROUTE cycle. Config changes in ROUTE or PAYLOAD do not affect the current frame.
- A header that drops valid while in ROUTE (protocol violation) is not handled; the FSM stays in ROUTE.
- Payload beats seen in IDLE or ROUTE are ignored for sequencing.

## Timing
- Reset values: enable=0, drop=0, select=0, busy=0, state=IDLE. Stats counters (if compiled in) are 0.
- Reset asserted mid-frame: all outputs return to reset values immediately. ip_demux shares the same rst.
- Decision latency: s_ip_hdr_valid rising in IDLE at cycle N gives enable=1 with valid select/drop at cycle N+1. The earliest header acceptance is cycle N+1.
- select and drop never change while enable=1.
- Back-to-back frames: the tlast handshake at cycle T gives enable=0 at T+1. A pending header is classified at T+1, and enable=1 at T+2. Minimum one idle cycle per frame.
- A header-valid and tlast handshake in the same PAYLOAD cycle: tlast wins. The new header is classified from IDLE in the next cycle.
- Classification is one registered stage; the compare tree is purely combinational in front of it.

## Configuration
- IP_DEMUX_CTRL_STATS_EN
  - Defined: adds output `stat_frames` (M_COUNT*16, per-output accepted-frame counts) and output `stat_drops` (16).
    - The relevant counter increments on the ROUTE→PAYLOAD transition.
    - Counters saturate at 0xFFFF and clear on rst.
    - Adds input `stat_clear` (1): synchronous clear of all counters. If clear and increment coincide, clear wins.
  - Undefined: these ports and the counter logic are absent; all other behaviour is identical.

## Test plan
- Rule 2 = proto 0x11, IP 192.168.1.0 mask 0xFFFFFF00, all other rules invalid. UDP frame to 192.168.1.77 → select=2, drop=0, enable=1 one cycle after hdr_valid, held through the 3-beat payload, enable=0 the cycle after tlast.
- Rules 1 and 3 both match (proto_any, mask 0) → select=1. Clear cfg_rule_valid[1] and send the next frame → select=3.
- No rule matches (proto 0x06, no TCP rule) → drop=1, select=0. With STATS_EN, stat_drops increments to 1.
- Back-to-back frames with hdr_valid held high at tlast → exactly one enable=0 cycle between frames; second-frame select correct.
- Change cfg_rule_ip[2] during PAYLOAD → select/drop unchanged until tlast; the next frame uses the new rule.
- Assert rst during PAYLOAD beat 2 of 4 → enable/drop/select/busy=0 in the same cycle; the next frame after reset is classified normally.
